// File: rtl/arb_pkg.sv
// Shared constants and FSM state type for the 8-way round-robin arbiter.
package arb_pkg;
  localparam int NUM_REQ = 8;
  localparam int ID_W    = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Pointer advance; 3-bit arithmetic gives the 7->0 wrap for free.
  function automatic logic [ID_W-1:0] id_inc(input logic [ID_W-1:0] v);
    return v + 1'b1;
  endfunction
endpackage

// File: rtl/or_8.sv
// 8-input OR reduction gate.
module or_8 (
  input  logic [7:0] in_i,
  output logic       out_o
);
  assign out_o = |in_i;
endmodule

// File: rtl/rr_pick_8.sv
// Combinational rotating-priority picker: first set req bit at or after ptr, wrapping.
module rr_pick_8
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [ID_W-1:0]    idx_o
);
  logic              found;
  logic [ID_W-1:0]   cand;

  always_comb begin
    found  = 1'b0;
    cand   = '0;
    idx_o  = '0;
    pick_o = '0;
    for (int d = 0; d < NUM_REQ; d++) begin
      cand = ptr_i + ID_W'(d);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    pick_o[idx_o] = found;
  end
endmodule

// File: rtl/arb_rr_8.sv
// 8-requester round-robin arbiter with registered one-hot grant.
// Optional forced release after MAX_HOLD busy cycles: define ARB_TIMEOUT_EN.
module arb_rr_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any_req,
  output logic               timeout
);
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("MAX_HOLD must be at least 1");
  end

  state_e             state_q;
  logic [ID_W-1:0]    ptr_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic               gnt_valid_q;
  logic [ID_W-1:0]    gnt_id_q;
  logic [NUM_REQ-1:0] pick;
  logic [ID_W-1:0]    pick_idx;
  logic               rel_d;
  logic               tmo_d;

  or_8 u_any (
    .in_i  (req),
    .out_o (any_req)
  );

  rr_pick_8 u_pick (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .pick_o (pick),
    .idx_o  (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_q;
  logic              timeout_q;
`endif

  // A normal release always wins over a simultaneous hold-limit hit.
  always_comb begin
    rel_d = done || !req[gnt_id_q];
`ifdef ARB_TIMEOUT_EN
    tmo_d = !rel_d && (hold_q == HOLD_W'(MAX_HOLD));
`else
    tmo_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q     <= BUSY;
            gnt_q       <= pick;
            gnt_valid_q <= 1'b1;
            gnt_id_q    <= pick_idx;
            ptr_q       <= id_inc(pick_idx);
`ifdef ARB_TIMEOUT_EN
            hold_q      <= HOLD_W'(1);
`endif
          end
        end
        BUSY: begin
          // Dropping to IDLE here guarantees the one-cycle gap before a regrant.
          if (rel_d || tmo_d) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_q      <= '0;
            timeout_q   <= tmo_d;
          end else begin
            hold_q      <= hold_q + 1'b1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif
endmodule

// File: tb/tb_arb_rr_8.sv
// Self-checking bench for arb_rr_8: directed scenarios plus random req/done vs. a holder-based model.
module tb_arb_rr_8;
  localparam int MAXH = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_id;
  logic       any_req;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  // Model: who holds the grant (-1 = nobody), whose turn starts the search, busy-cycle count.
  int m_holder = -1;
  int m_ptr    = 0;
  int m_cnt    = 0;
  bit m_tmo    = 1'b0;

  arb_rr_8 #(.MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .any_req   (any_req),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [7:0] r, input bit d, input bit rs);
    m_tmo = 1'b0;
    if (rs) begin
      m_holder = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_holder < 0) begin
      for (int k = 0; k < 8; k++) begin
        if (r[(m_ptr + k) % 8]) begin
          m_holder = (m_ptr + k) % 8;
          break;
        end
      end
      if (m_holder >= 0) begin
        m_ptr = (m_holder + 1) % 8;
        m_cnt = 1;
      end
    end else if (d || !r[m_holder]) begin
      m_holder = -1; m_cnt = 0;
    end else if (TMO && m_cnt == MAXH) begin
      m_holder = -1; m_cnt = 0; m_tmo = 1'b1;
    end else begin
      m_cnt++;
    end
  endtask

  // One clock: drive on negedge, advance model with the sampled inputs, compare #1 after the edge.
  task automatic step(input logic [7:0] r, input bit d, input bit rs);
    logic [7:0] eg;
    @(negedge clk);
    req = r; done = d; rst = rs;
    @(posedge clk);
    model_edge(r, d, rs);
    #1;
    eg = (m_holder < 0) ? 8'h00 : 8'(1 << m_holder);
    chk("gnt", {24'd0, gnt}, {24'd0, eg});
    chk("gnt_valid", {31'd0, gnt_valid}, {31'd0, m_holder >= 0});
    chk("gnt_id", {29'd0, gnt_id}, (m_holder < 0) ? 32'd0 : 32'(m_holder));
    chk("timeout", {31'd0, timeout}, {31'd0, m_tmo});
    chk("any_req", {31'd0, any_req}, {31'd0, r != 8'h00});
  endtask

  initial begin
    logic [7:0] r;
    bit d, rs;

    // Reset state
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    chk("reset_gnt", {24'd0, gnt}, 32'h0);
    step(8'h00, 1'b1, 1'b0);
    chk("idle_done_ignored", {24'd0, gnt}, 32'h0);

    // req=0000_0101: 0 first, then 2 after a one-cycle gap
    step(8'h05, 1'b0, 1'b0);
    chk("basic_first", {24'd0, gnt}, 32'h01);
    step(8'h05, 1'b1, 1'b0);
    chk("basic_gap", {24'd0, gnt}, 32'h00);
    step(8'h05, 1'b0, 1'b0);
    chk("basic_second", {24'd0, gnt}, 32'h04);

    // All requesting: order 0..7,0 with one idle cycle between grants
    step(8'hFF, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) begin
      step(8'hFF, 1'b0, 1'b0);
      chk($sformatf("rr_order_%0d", k), {24'd0, gnt}, 32'(1 << (k % 8)));
      step(8'hFF, 1'b1, 1'b0);
      chk($sformatf("rr_gap_%0d", k), {24'd0, gnt}, 32'h0);
    end

    // Holder 3: other bits churn, then req[3] drops without done
    step(8'h00, 1'b0, 1'b1);
    step(8'h08, 1'b0, 1'b0);
    chk("hold3_grant", {24'd0, gnt}, 32'h08);
    step(8'hFF, 1'b0, 1'b0);
    step(8'h48, 1'b0, 1'b0);
    chk("hold3_stable", {24'd0, gnt}, 32'h08);
    step(8'hF7, 1'b0, 1'b0);
    chk("hold3_drop", {24'd0, gnt}, 32'h00);
    step(8'hF7, 1'b0, 1'b0);
    chk("hold3_next", {24'd0, gnt}, 32'h10);

    // Reset mid-grant, then requester 0 has top priority again
    step(8'h00, 1'b0, 1'b1);
    step(8'h10, 1'b0, 1'b0);
    chk("rst_mid_pre", {24'd0, gnt}, 32'h10);
    step(8'h11, 1'b0, 1'b1);
    chk("rst_mid_gnt", {24'd0, gnt}, 32'h00);
    chk("rst_mid_tmo", {31'd0, timeout}, 32'h0);
    step(8'h11, 1'b0, 1'b0);
    chk("rst_then_0", {24'd0, gnt}, 32'h01);

    // Hold-limit behaviour with a single requester and no done
    step(8'h00, 1'b0, 1'b1);
    if (TMO) begin
      for (int k = 0; k < MAXH; k++) begin
        step(8'h01, 1'b0, 1'b0);
        chk($sformatf("tmo_held_%0d", k), {24'd0, gnt}, 32'h01);
      end
      step(8'h01, 1'b0, 1'b0);
      chk("tmo_drop", {24'd0, gnt}, 32'h00);
      chk("tmo_pulse", {31'd0, timeout}, 32'h1);
      step(8'h01, 1'b0, 1'b0);
      chk("tmo_regrant", {24'd0, gnt}, 32'h01);
      chk("tmo_pulse_end", {31'd0, timeout}, 32'h0);
      for (int k = 0; k < MAXH - 1; k++) step(8'h01, 1'b0, 1'b0);
      step(8'h01, 1'b1, 1'b0);
      chk("tmo_done_wins", {31'd0, timeout}, 32'h0);
      chk("tmo_done_gnt", {24'd0, gnt}, 32'h00);
    end else begin
      for (int k = 0; k < 3 * MAXH; k++) step(8'h01, 1'b0, 1'b0);
      chk("no_tmo_held", {24'd0, gnt}, 32'h01);
      chk("no_tmo_pulse", {31'd0, timeout}, 32'h0);
    end

    // Random traffic with structural invariants
    for (int n = 0; n < 10000; n++) begin
      r  = 8'($urandom) & 8'($urandom);
      d  = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 199) == 0);
      step(r, d, rs);
      chk("inv_onehot0", {31'd0, $onehot0(gnt)}, 32'h1);
      chk("inv_valid", {31'd0, gnt_valid}, {31'd0, gnt != 8'h00});
      chk("inv_id", {24'd0, gnt}, gnt_valid ? 32'(1 << gnt_id) : 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/arb_rr_8.md
ARB_RR_8 -- requirements
Module: arb_rr_8

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 15, meaning the maximum number of cycles a grant is held before forced release (used only with ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1, the sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req, input, 8, per-requester request level; bit i is requester i.
REQ-005 SHALL have port done, input, 1, one-cycle release pulse from the current grant holder.
REQ-006 SHALL have port gnt, output, 8, registered one-hot grant vector.
REQ-007 SHALL have port gnt_valid, output, 1, registered; high exactly when gnt is non-zero.
REQ-008 SHALL have port gnt_id, output, 3, registered binary index of the granted requester; 0 when gnt_valid is low.
REQ-009 SHALL have port any_req, output, 1, combinational 8-input OR of req.
REQ-010 SHALL have port timeout, output, 1, registered one-cycle pulse on forced release; tied 0 without ARB_TIMEOUT_EN.

Function
REQ-011 SHALL implement a two-state FSM: IDLE (no grant) and BUSY (one grant held).
REQ-012 In IDLE with any_req high, SHALL select the winner by rotating priority starting at pointer ptr, wrapping 7->0, and enter BUSY with gnt/gnt_valid/gnt_id valid on the next cycle (1-cycle latency).
REQ-013 In IDLE with any_req low, SHALL remain in IDLE with all outputs 0.
REQ-014 On entering BUSY with winner w, SHALL set ptr to (w+1) mod 8.
REQ-015 In BUSY, SHALL hold gnt constant regardless of changes on other req bits.
REQ-016 In BUSY, SHALL release (return to IDLE, gnt=0 next cycle) when done is high, or when req[gnt_id] is low.
REQ-017 SHALL ignore done while in IDLE.
REQ-018 After release, SHALL spend exactly one IDLE cycle before any new grant (minimum gap 1 cycle), even if requests are pending.
REQ-019 SHALL never assert more than one gnt bit in any cycle.
REQ-020 A requester re-requesting after release SHALL not win again while any other requester is pending (starvation-free; worst-case wait 7 grant tenures).
REQ-021 Simultaneous done and req[gnt_id] low SHALL count as a single release.

Reset
REQ-022 With rst high at a clock edge, SHALL force state IDLE, ptr=0, hold counter=0, gnt=0, gnt_valid=0, gnt_id=0, timeout=0 on the next cycle.
REQ-023 Reset asserted mid-grant SHALL drop the grant immediately (next edge) without asserting timeout.
REQ-024 The first grant after reset SHALL give requester 0 the highest priority.

Configuration
REQ-025 With macro ARB_TIMEOUT_EN defined, SHALL count cycles in BUSY from 1 and, when the count equals MAX_HOLD without release, force release and pulse timeout for one cycle coincident with gnt dropping.
REQ-026 With ARB_TIMEOUT_EN undefined, SHALL omit the hold counter, hold grants indefinitely until REQ-016 release, and tie timeout to 0.
REQ-027 With ARB_TIMEOUT_EN defined, a normal release on the same cycle the count reaches MAX_HOLD SHALL take precedence, and timeout SHALL stay 0.

Structure
REQ-028 Shared package arb_pkg SHALL hold NUM_REQ=8, ID_W=3, and the FSM state typedef (IDLE, BUSY).
REQ-029 SHALL instantiate one combinational sub-module rr_pick_8 (inputs req, ptr; outputs one-hot pick and binary index).
REQ-030 any_req SHALL reuse the team's existing 8-input OR gate module.

Verification
REQ-031 Reset, then req=8'b0000_0101 held -> gnt=0000_0001 at cycle+1; done -> after 1-cycle gap, gnt=0000_0100.
REQ-032 req=8'hFF held, done after each grant -> grant order 0,1,2,...,7,0 with exactly one idle cycle between grants.
REQ-033 Holder 3 granted, req[3] dropped with done low -> gnt=0 next cycle; other req changes during BUSY never alter gnt.
REQ-034 ARB_TIMEOUT_EN, MAX_HOLD=4, req=8'h01 held, no done -> gnt high 4 cycles, then gnt=0 with timeout=1 for one cycle, regrant after gap.
REQ-035 rst asserted while gnt=0001_0000 -> next cycle all outputs 0, timeout=0; next grant with req=8'h11 goes to requester 0.
REQ-036 Random req/done for 10k cycles -> gnt always one-hot or zero, gnt_valid == (gnt != 0), gnt_id consistent with gnt.
